siftedkey_compactor: RTL

//  Multi-cycle, parametrised successor to the single-cycle sifted-key packer.

---
 rtl/siftedkey_compactor.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/siftedkey_compactor.sv
// siftedkey_compactor
// Captures sender/receiver sifted bits and valid masks on an accepted start,
// then walks LANE positions per cycle, packing each side's valid bits into a
// dense LSB-first key. After the last chunk it publishes the final lengths,
// a length-mismatch flag and a key-sufficient flag alongside a one-cycle done.
//
// Handshake: start is a one-cycle request sampled on the rising edge and only
// honoured in IDLE; busy is high for exactly the N_BITS/LANE RUN cycles; done
// is a single-cycle pulse, and results hold until the next accepted start.
module siftedkey_compactor #(
  parameter int N_BITS  = 640,
  parameter int LANE    = 32,
  parameter int LEN_W   = 11,
  parameter int KEY_LEN = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_BITS-1:0] sender_sifted,
  input  logic [N_BITS-1:0] sender_svalid,
  input  logic [N_BITS-1:0] receiver_sifted,
  input  logic [N_BITS-1:0] receiver_svalid,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] sender_vsifted,
  output logic [N_BITS-1:0] receiver_vsifted,
  output logic [LEN_W-1:0]  sender_len,
  output logic [LEN_W-1:0]  receiver_len,
  output logic              len_mismatch,
  output logic              key_ok,
  output logic [1:0]        dbg_state_o
);

  localparam int N_CHUNKS = N_BITS / LANE;
  localparam int PTR_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int IDX_W    = $clog2(N_BITS);
  localparam int CMP_W    = N_BITS + LEN_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_BITS-1:0] s_sift_q, s_sift_d, s_vld_q, s_vld_d;
  logic [N_BITS-1:0] r_sift_q, r_sift_d, r_vld_q, r_vld_d;
  logic [N_BITS-1:0] s_vs_q, s_vs_d, r_vs_q, r_vs_d;
  logic [LEN_W-1:0]  s_len_q, s_len_d, r_len_q, r_len_d;
  logic              mism_q, mism_d, ok_q, ok_d;

  logic              last_chunk;
  logic [IDX_W-1:0]  base;
  logic [CMP_W-1:0]  s_cmp, r_cmp;
  logic [N_BITS-1:0] s_vs_n, r_vs_n;
  logic [LEN_W-1:0]  s_len_n, r_len_n;

  // Packs the valid bits of one chunk into vec starting at index len.
  // len never exceeds the number of positions already examined, so the
  // write index stays below N_BITS; the guard keeps that explicit.
  function automatic logic [CMP_W-1:0] compact(
    input logic [N_BITS-1:0] vec,
    input logic [LEN_W-1:0]  len,
    input logic [LANE-1:0]   bits,
    input logic [LANE-1:0]   vld
  );
    logic [N_BITS-1:0] v;
    logic [LEN_W-1:0]  l;
    v = vec;
    l = len;
    for (int i = 0; i < LANE; i++) begin
      if (vld[i]) begin
        if (l < LEN_W'(N_BITS)) v[l[IDX_W-1:0]] = bits[i];
        l = l + LEN_W'(1);
      end
    end
    return {l, v};
  endfunction

  assign last_chunk = (ptr_q == PTR_W'(N_CHUNKS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a start in RUN or DONE is simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_chunk) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded directly from state.
  always_comb begin
    busy        = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    dbg_state_o = state_q;
  end

  // Compaction of the current chunk for both sides.
  always_comb begin
    base  = IDX_W'(ptr_q) * IDX_W'(LANE);
    s_cmp = compact(s_vs_q, s_len_q, s_sift_q[base +: LANE], s_vld_q[base +: LANE]);
    r_cmp = compact(r_vs_q, r_len_q, r_sift_q[base +: LANE], r_vld_q[base +: LANE]);
    {s_len_n, s_vs_n} = s_cmp;
    {r_len_n, r_vs_n} = r_cmp;
  end

  // Datapath next-state: capture on accepted start, accumulate in RUN, and
  // latch the flags on the last chunk so they are valid during done.
  always_comb begin
    ptr_d    = ptr_q;
    s_sift_d = s_sift_q;
    s_vld_d  = s_vld_q;
    r_sift_d = r_sift_q;
    r_vld_d  = r_vld_q;
    s_vs_d   = s_vs_q;
    r_vs_d   = r_vs_q;
    s_len_d  = s_len_q;
    r_len_d  = r_len_q;
    mism_d   = mism_q;
    ok_d     = ok_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          s_sift_d = sender_sifted;
          s_vld_d  = sender_svalid;
          r_sift_d = receiver_sifted;
          r_vld_d  = receiver_svalid;
          s_vs_d   = '0;
          r_vs_d   = '0;
          s_len_d  = '0;
          r_len_d  = '0;
          mism_d   = 1'b0;
          ok_d     = 1'b0;
          ptr_d    = '0;
        end
      end
      S_RUN: begin
        s_vs_d  = s_vs_n;
        r_vs_d  = r_vs_n;
        s_len_d = s_len_n;
        r_len_d = r_len_n;
        if (last_chunk) begin
          mism_d = (s_len_n != r_len_n);
          ok_d   = (s_len_n == r_len_n) && (s_len_n >= LEN_W'(KEY_LEN));
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything so outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      s_sift_q <= '0;
      s_vld_q  <= '0;
      r_sift_q <= '0;
      r_vld_q  <= '0;
      s_vs_q   <= '0;
      r_vs_q   <= '0;
      s_len_q  <= '0;
      r_len_q  <= '0;
      mism_q   <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      s_sift_q <= s_sift_d;
      s_vld_q  <= s_vld_d;
      r_sift_q <= r_sift_d;
      r_vld_q  <= r_vld_d;
      s_vs_q   <= s_vs_d;
      r_vs_q   <= r_vs_d;
      s_len_q  <= s_len_d;
      r_len_q  <= r_len_d;
      mism_q   <= mism_d;
      ok_q     <= ok_d;
    end
  end

  assign sender_vsifted   = s_vs_q;
  assign receiver_vsifted = r_vs_q;
  assign sender_len       = s_len_q;
  assign receiver_len     = r_len_q;
  assign len_mismatch     = mism_q;
  assign key_ok           = ok_q;

endmodule
